writeback_regfile: RTL

WRITEBACK_REGFILE -- requirements
Module: writeback_regfile

---
 rtl/writeback_regfile.sv | 118 +++++++++++
 1 files changed

// File: rtl/writeback_regfile.sv
// Y86-64 writeback stage: 15 x 64-bit register file, processor status and retire counter.
// Define WB_BYPASS_EN to forward the pending writeback data onto the decode read ports.
module writeback_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  w_stat,
    input  logic [3:0]  w_icode,
    input  logic [3:0]  w_rA,
    input  logic [3:0]  w_rB,
    input  logic        w_cnd,
    input  logic [63:0] w_valE,
    input  logic [63:0] w_valM,
    input  logic [3:0]  d_srcA,
    input  logic [3:0]  d_srcB,
    output logic [63:0] d_rvalA,
    output logic [63:0] d_rvalB,
    output logic [2:0]  proc_stat,
    output logic        halted,
    output logic [63:0] retired
);

    localparam int          NUM_REGS = 15;
    localparam logic [3:0]  REG_RSP  = 4'h4;
    localparam logic [3:0]  REG_NONE = 4'hF;
    localparam logic [2:0]  STAT_AOK = 3'd1;

    localparam logic [3:0]  I_NOP    = 4'h1;
    localparam logic [3:0]  I_CMOVXX = 4'h2;
    localparam logic [3:0]  I_IRMOVQ = 4'h3;
    localparam logic [3:0]  I_MRMOVQ = 4'h5;
    localparam logic [3:0]  I_OPQ    = 4'h6;
    localparam logic [3:0]  I_CALL   = 4'h8;
    localparam logic [3:0]  I_RET    = 4'h9;
    localparam logic [3:0]  I_PUSHQ  = 4'hA;
    localparam logic [3:0]  I_POPQ   = 4'hB;

    logic [63:0] regs [0:NUM_REGS-1];
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
    logic        wr_en;

    // NOTE: every variable written in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        dst_e = REG_NONE;
        case (w_icode)
            I_CMOVXX:                        if (w_cnd) dst_e = w_rB;
            I_IRMOVQ, I_OPQ:                 dst_e = w_rB;
            I_CALL, I_RET, I_PUSHQ, I_POPQ:  dst_e = REG_RSP;
            default:                         dst_e = REG_NONE;
        endcase
    end

    always_comb begin
        dst_m = REG_NONE;
        case (w_icode)
            I_MRMOVQ, I_POPQ: dst_m = w_rA;
            default:          dst_m = REG_NONE;
        endcase
    end

    // An exceptional status stops the machine on the same edge it is seen, so it never writes.
    assign wr_en = (w_stat == STAT_AOK) && !halted;

    // NOTE: this array is flops rather than a RAM, so every entry is cleared explicitly on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            // dstM is tested first so popq %rsp keeps the loaded value, not the incremented pointer.
            for (int i = 0; i < NUM_REGS; i++) begin
                if (dst_m == 4'(i)) begin
                    regs[i] <= w_valM;
                end else if (dst_e == 4'(i)) begin
                    regs[i] <= w_valE;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            proc_stat <= STAT_AOK;
            halted    <= 1'b0;
            retired   <= '0;
        end else if (!halted) begin
            if (w_stat != STAT_AOK) begin
                proc_stat <= w_stat;
                halted    <= 1'b1;
            end else if (w_icode != I_NOP) begin
                retired <= retired + 64'd1;
            end
        end
    end

    function automatic logic [63:0] read_port(input logic [3:0] addr);
        if (addr == REG_NONE) begin
            return '0;
        end
`ifdef WB_BYPASS_EN
        if (wr_en && (dst_m == addr)) begin
            return w_valM;
        end
        if (wr_en && (dst_e == addr)) begin
            return w_valE;
        end
`endif
        return regs[addr];
    endfunction

    always_comb begin
        d_rvalA = read_port(d_srcA);
        d_rvalB = read_port(d_srcB);
    end

endmodule
